mem_port_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-fetch requester and the data-cache refill/write-back requester of the pipelined MIPS core.
- Accepts one access at a time, drives the memory for a fixed LATENCY-cycle window, then returns read data with a one-cycle ack.
- Fixed priority goes to data, because data stalls freeze the whole pipeline.
- A starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and data-cache refill/write-back. Data has fixed priority. A starvation
// counter forces a waiting fetch through after STARVE_MAX consecutive data
// grants. Each access holds the memory port for LATENCY cycles, then the
// owner gets a one-cycle ack with its read data registered.
module mem_port_arbiter #(
  parameter int LATENCY    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1     = 4'(LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;

  logic force_fetch;
  logic grant_d;
  logic grant_f;

  // Word addresses only: the byte-offset bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Saturating increment of the consecutive-data-grant counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= STARVE_LIM) begin
      return STARVE_LIM;
    end
    return v + 4'd1;
  endfunction

  // Arbitration decision, only consumed while the FSM is in IDLE.
  always_comb begin
    force_fetch = if_req && (starve_cnt == STARVE_LIM);
    grant_d     = d_req && !force_fetch;
    grant_f     = if_req && !grant_d;
  end

  // Access FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      starve_cnt <= 4'd0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr   <= {d_addr[31:2], 2'b00};
            mem_wdata  <= d_wdata;
            mem_we     <= d_we;
            owner      <= 1'b1;
            cnt        <= LAT_M1;
            busy       <= 1'b1;
            state      <= ACCESS;
            // Only data grants that overtake a waiting fetch count toward starvation.
            starve_cnt <= if_req ? sat_inc(starve_cnt) : 4'd0;
          end else if (grant_f) begin
            // Fetch is read-only; the write-data register is left as it was.
            mem_addr   <= {if_addr[31:2], 2'b00};
            mem_we     <= 1'b0;
            owner      <= 1'b0;
            cnt        <= LAT_M1;
            busy       <= 1'b1;
            state      <= ACCESS;
            starve_cnt <= 4'd0;
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last cycle of the window: memory data is valid now.
            if (!mem_we) begin
              if (owner) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (owner) begin
              d_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            mem_we <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // Ack cycle; no arbitration so the requester can drop its request.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with LATENCY=4
// (instance a) and LATENCY=1 (instance b), plus a randomized protocol run.
module tb_mem_port_arbiter;

  logic clk;

  // Instance a: LATENCY=4, STARVE_MAX=3
  logic        reset_a;
  logic        if_req_a;
  logic [31:0] if_addr_a;
  logic        if_ack_a;
  logic [31:0] if_rdata_a;
  logic        d_req_a;
  logic        d_we_a;
  logic [31:0] d_addr_a;
  logic [31:0] d_wdata_a;
  logic        d_ack_a;
  logic [31:0] d_rdata_a;
  logic [31:0] mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic        mem_we_a;
  logic [31:0] mem_rdata_a;
  logic        busy_a;
  logic        owner_a;

  // Instance b: LATENCY=1, STARVE_MAX=3
  logic        reset_b;
  logic        if_req_b;
  logic [31:0] if_addr_b;
  logic        if_ack_b;
  logic [31:0] if_rdata_b;
  logic        d_req_b;
  logic        d_we_b;
  logic [31:0] d_addr_b;
  logic [31:0] d_wdata_b;
  logic        d_ack_b;
  logic [31:0] d_rdata_b;
  logic [31:0] mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic        mem_we_b;
  logic [31:0] mem_rdata_b;
  logic        busy_b;
  logic        owner_b;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.LATENCY(4), .STARVE_MAX(3)) u_dut_a (
    .clk(clk), .reset(reset_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_ack(d_ack_a), .d_rdata(d_rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a)
  );

  mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(3)) u_dut_b (
    .clk(clk), .reset(reset_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ack(d_ack_b), .d_rdata(d_rdata_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access on instance a, starting with the request already
  // driven in an IDLE cycle so the grant lands on the next rising edge.
  task automatic do_access(input logic own, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input logic [31:0] exp_rdata);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val("acc_busy", 32'(busy_a), 32'd1);
      check_val("acc_owner", 32'(owner_a), 32'(own));
      check_val("acc_addr", mem_addr_a, addr);
      check_val("acc_we", 32'(mem_we_a), 32'(we));
      if (we) check_val("acc_wdata", mem_wdata_a, wdata);
      check_val("acc_no_ack", 32'({if_ack_a, d_ack_a}), 32'd0);
      mem_rdata_a = (k == 4) ? rd : 32'h0BAD_F00D;
    end
    @(negedge clk);
    check_val("resp_if_ack", 32'(if_ack_a), 32'(!own));
    check_val("resp_d_ack", 32'(d_ack_a), 32'(own));
    check_val("resp_we", 32'(mem_we_a), 32'd0);
    check_val("resp_busy", 32'(busy_a), 32'd1);
    check_val("resp_rdata", own ? d_rdata_a : if_rdata_a, exp_rdata);
    if (own) d_req_a = 1'b0;
    else if_req_a = 1'b0;
    mem_rdata_a = 32'h0BAD_F00D;
    @(negedge clk);
    check_val("idle_busy", 32'(busy_a), 32'd0);
    check_val("idle_no_ack", 32'({if_ack_a, d_ack_a}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_order[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int ng;
    int t;
    int na;
    int ack_cyc[4];
    int n_acks;
    logic prev_busy;

    reset_a = 1'b1; if_req_a = 1'b0; if_addr_a = 32'd0; d_req_a = 1'b0;
    d_we_a = 1'b0; d_addr_a = 32'd0; d_wdata_a = 32'd0; mem_rdata_a = 32'h0BAD_F00D;
    reset_b = 1'b1; if_req_b = 1'b0; if_addr_b = 32'd0; d_req_b = 1'b0;
    d_we_b = 1'b0; d_addr_b = 32'd0; d_wdata_b = 32'd0; mem_rdata_b = 32'd0;

    repeat (3) @(negedge clk);
    check_val("rst_if_ack", 32'(if_ack_a), 32'd0);
    check_val("rst_d_ack", 32'(d_ack_a), 32'd0);
    check_val("rst_if_rdata", if_rdata_a, 32'd0);
    check_val("rst_d_rdata", d_rdata_a, 32'd0);
    check_val("rst_mem_addr", mem_addr_a, 32'd0);
    check_val("rst_mem_wdata", mem_wdata_a, 32'd0);
    check_val("rst_mem_we", 32'(mem_we_a), 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_owner", 32'(owner_a), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check_val("idle_after_rst", 32'(busy_a), 32'd0);

    // Single fetch
    if_req_a = 1'b1; if_addr_a = 32'h0000_0040;
    do_access(1'b0, 32'h0000_0040, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check_val("fetch_d_rdata_untouched", d_rdata_a, 32'd0);

    // Data write, unaligned address
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 32'h0000_0103; d_wdata_a = 32'h1122_3344;
    do_access(1'b1, 32'h0000_0100, 1'b1, 32'h1122_3344, 32'h9999_9999, 32'd0);
    check_val("write_if_rdata_held", if_rdata_a, 32'hDEAD_BEEF);

    // Data read
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h0000_0200;
    do_access(1'b1, 32'h0000_0200, 1'b0, 32'd0, 32'hCAFE_0001, 32'hCAFE_0001);
    check_val("read_if_rdata_held", if_rdata_a, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, fetch immediately after
    if_req_a = 1'b1; if_addr_a = 32'h0000_0080;
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h0000_0300;
    do_access(1'b1, 32'h0000_0300, 1'b0, 32'd0, 32'hA5A5_0003, 32'hA5A5_0003);
    do_access(1'b0, 32'h0000_0080, 1'b0, 32'd0, 32'h1234_5678, 32'h1234_5678);
    check_val("arb_d_rdata_held", d_rdata_a, 32'hA5A5_0003);

    // Starvation: both requesters held high
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 32'h0000_0500;
    if_req_a = 1'b1; if_addr_a = 32'h0000_0600;
    ng = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 100 && ng < 8; c++) begin
      @(negedge clk);
      if (busy_a && !prev_busy) begin
        check_val($sformatf("starve_grant%0d", ng), 32'(owner_a), 32'(exp_order[ng]));
        ng++;
      end
      prev_busy = busy_a;
    end
    check_val("starve_grant_count", 32'(ng), 32'd8);
    t = 0;
    while (!if_ack_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("starve_final_if_ack", 32'(if_ack_a), 32'd1);
    if_req_a = 1'b0;
    d_req_a = 1'b0;
    @(negedge clk);
    check_val("starve_idle", 32'(busy_a), 32'd0);

    // Reset during the 2nd ACCESS cycle of a write
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 32'h0000_0400; d_wdata_a = 32'h55AA_55AA;
    @(negedge clk);
    check_val("rstmid_we_c1", 32'(mem_we_a), 32'd1);
    @(negedge clk);
    check_val("rstmid_we_c2", 32'(mem_we_a), 32'd1);
    reset_a = 1'b1;
    d_req_a = 1'b0;
    @(negedge clk);
    check_val("rstmid_we", 32'(mem_we_a), 32'd0);
    check_val("rstmid_busy", 32'(busy_a), 32'd0);
    check_val("rstmid_ack", 32'({if_ack_a, d_ack_a}), 32'd0);
    check_val("rstmid_addr", mem_addr_a, 32'd0);
    check_val("rstmid_d_rdata", d_rdata_a, 32'd0);
    check_val("rstmid_if_rdata", if_rdata_a, 32'd0);
    reset_a = 1'b0;
    @(negedge clk);
    check_val("rstmid_post_ack", 32'({if_ack_a, d_ack_a}), 32'd0);
    check_val("rstmid_post_busy", 32'(busy_a), 32'd0);
    if_req_a = 1'b1; if_addr_a = 32'h0000_0044;
    do_access(1'b0, 32'h0000_0044, 1'b0, 32'd0, 32'h0F0F_0F0F, 32'h0F0F_0F0F);

    // LATENCY=1: back-to-back fetches with if_req held
    mem_rdata_b = 32'h0000_0077;
    if_req_b = 1'b1; if_addr_b = 32'h0000_0010;
    na = 0;
    for (int c = 1; c <= 20 && na < 4; c++) begin
      @(negedge clk);
      if (if_ack_b) begin
        ack_cyc[na] = c;
        na++;
      end
    end
    check_val("l1_ack_count", 32'(na), 32'd4);
    check_val("l1_first_ack", 32'(ack_cyc[0]), 32'd2);
    check_val("l1_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    check_val("l1_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    check_val("l1_gap3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd3);
    check_val("l1_if_rdata", if_rdata_b, 32'h0000_0077);
    if_req_b = 1'b0;
    @(negedge clk);

    // Randomized traffic on the LATENCY=1 instance
    n_acks = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check_val("rand_ack_overlap", 32'(if_ack_b & d_ack_b), 32'd0);
      check_val("rand_we_idle", 32'(mem_we_b & ~busy_b), 32'd0);
      if (if_ack_b) n_acks++;
      if (d_ack_b) n_acks++;
      mem_rdata_b = $urandom;
      if (if_ack_b) begin
        if_req_b = 1'b0;
      end else if (!if_req_b && ($urandom_range(0, 3) == 0)) begin
        if_req_b = 1'b1;
        if_addr_b = $urandom;
      end
      if (d_ack_b) begin
        d_req_b = 1'b0;
      end else if (!d_req_b && ($urandom_range(0, 2) == 0)) begin
        d_req_b = 1'b1;
        d_we_b = 1'($urandom_range(0, 1));
        d_addr_b = $urandom;
        d_wdata_b = $urandom;
      end
    end
    check_val("rand_progress", 32'(n_acks > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
